// File: rtl/ys_poly_pkg.sv
// Shared encodings and defaults for the small polynomial difference/scale block.
package ys_poly_pkg;

    localparam int COEF_W_DEF = 13;
    localparam int LANES_DEF  = 8;

    typedef enum logic [1:0] {
        MODE_COPY  = 2'd0,
        MODE_DIFF3 = 2'd1,
        MODE_DIFF  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/poly_small_lane_op.sv
// One lane of the difference/scale datapath: combinational (prev, cur, mode, first) -> result.
module poly_small_lane_op
    import ys_poly_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic [COEF_W-1:0] prev,
    input  logic [COEF_W-1:0] cur,
    input  mode_e             mode,
    input  logic              first,
    output logic [COEF_W-1:0] res
);

    logic [COEF_W-1:0] base;
    logic [COEF_W-1:0] diff;
    logic [COEF_W-1:0] dbl;

    always_comb begin
        // First beat of a polynomial has no predecessor, so the difference degenerates to -cur.
        base = first ? '0 : prev;
        diff = base - cur;
        dbl  = diff << 1;
        case (mode)
            MODE_DIFF3: res = dbl + diff;
            MODE_DIFF:  res = diff;
            default:    res = cur;
        endcase
    end

endmodule

// File: rtl/poly_small_diff_scale.sv
// Streaming lane-wise difference (optionally x3) over polynomial coefficient beats.
// Optional beat-count checking is enabled with `define POLY_SMALL_DS_BEATCHK_EN.
module poly_small_diff_scale
    import ys_poly_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int NBEATS = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*COEF_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*COEF_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    state_e state, state_nxt;
    mode_e  mode_q;
    logic   first_q;
    logic   accept;
    logic   start_ok;
    logic [COEF_W-1:0]             carry;
    logic [LANES-1:0][COEF_W-1:0]  in_lanes;
    logic [LANES-1:0][COEF_W-1:0]  prev_lanes;
    logic [LANES-1:0][COEF_W-1:0]  res_lanes;

    assign in_lanes = in_data;
    assign start_ok = start && (state == ST_IDLE);
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == 0) begin : g_first
            assign prev_lanes[k] = carry;
        end else begin : g_rest
            assign prev_lanes[k] = in_lanes[k-1];
        end

        poly_small_lane_op #(.COEF_W(COEF_W)) u_op (
            .prev  (prev_lanes[k]),
            .cur   (in_lanes[k]),
            .mode  (mode_q),
            .first ((k == 0) ? first_q : 1'b0),
            .res   (res_lanes[k])
        );
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_valid && out_ready && out_last) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_COPY;
            carry     <= '0;
            first_q   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                mode_q  <= mode_e'(mode);
                carry   <= '0;
                first_q <= 1'b1;
            end
            // A new beat may land in the same cycle the previous one is taken downstream.
            if (accept) begin
                out_data  <= res_lanes;
                out_valid <= 1'b1;
                out_last  <= in_last;
                carry     <= in_lanes[LANES-1];
                first_q   <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef POLY_SMALL_DS_BEATCHK_EN
    localparam int CNT_W = $clog2(NBEATS + 1);

    logic [CNT_W-1:0] beat_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (start_ok) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (in_last != (beat_cnt == CNT_W'(NBEATS - 1)))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // NBEATS only matters when beat checking is built in; this is constant 0.
    assign err = (NBEATS < 0);
`endif

endmodule

// File: tb/tb_poly_small_diff_scale.sv
// Directed bench for poly_small_diff_scale with hand-computed expected lanes.
module tb_poly_small_diff_scale;

    localparam int CW = 13;
    localparam int LN = 8;
`ifdef POLY_SMALL_DS_BEATCHK_EN
    localparam int NB = 4;
    localparam logic ERR_EXP = 1'b1;
`else
    localparam int NB = 128;
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_last, busy, done, err;
    logic [LN-1:0][CW-1:0] v = '0;
    logic [LN-1:0][CW-1:0] a, b;
    logic [LN-1:0][CW-1:0] ol;
    logic [LN*CW-1:0] out_data;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign ol = out_data;

    poly_small_diff_scale #(.COEF_W(CW), .LANES(LN), .NBEATS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (v),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        tick();
        chk("done_clear", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();

        // DIFF3 single beat 1..8
        do_start(2'd1);
        chk("run_busy", busy, 1);
        for (int k = 0; k < LN; k++) v[k] = CW'(k + 1);
        send(1'b1);
        chk("d3_valid", out_valid, 1);
        chk("d3_last", out_last, 1);
        chk("d3_lane0", ol[0], 13'h1FFD);
        chk("d3_all", out_data, {LN{13'h1FFD}});
        tick();
        chk("d3_done", done, 1);
        tick();
        chk("d3_done_once", done, 0);
        chk("d3_idle", busy, 0);

        // DIFF3 carry across beats
        do_start(2'd1);
        for (int k = 0; k < LN; k++) v[k] = CW'(k);
        send(1'b0);
        chk("d3c_b1_lane0", ol[0], 0);
        chk("d3c_b1_lane1", ol[1], 13'h1FFD);
        v = '0;
        v[0] = 13'd10;
        send(1'b1);
        chk("d3c_b2_lane0", ol[0], 13'h1FF7);
        chk("d3c_b2_lane1", ol[1], 13'd30);
        chk("d3c_b2_lane2", ol[2], 0);
        wait_done();

        // backpressure in COPY mode
        do_start(2'd0);
        out_ready = 1'b0;
        for (int k = 0; k < LN; k++) a[k] = CW'(k + 100);
        for (int k = 0; k < LN; k++) b[k] = CW'(k + 200);
        v = a;
        send(1'b0);
        v = b;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", out_data, a);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_second_data", out_data, b);
        chk("bp_second_last", out_last, 1);
        tick();
        chk("bp_done", done, 1);
        tick();

        // reset mid-polynomial
        do_start(2'd2);
        for (int k = 0; k < LN; k++) v[k] = CW'(k * 7 + 3);
        send(1'b0);
        send(1'b0);
        rst = 1'b1;
        tick();
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        rst = 1'b0;
        tick();
        do_start(2'd2);
        for (int k = 0; k < LN; k++) v[k] = CW'(k + 5);
        send(1'b1);
        chk("mr_diff_lane0", ol[0], 13'h1FFB);
        chk("mr_diff_lane1", ol[1], 13'h1FFF);
        chk("mr_diff_lane7", ol[7], 13'h1FFF);
        wait_done();

        // start ignored while running
        do_start(2'd0);
        for (int k = 0; k < LN; k++) v[k] = CW'(k + 300);
        send(1'b0);
        chk("cp_b1", out_data, v);
        do_start(2'd1);
        for (int k = 0; k < LN; k++) v[k] = CW'(k * 3 + 400);
        send(1'b1);
        chk("cp_b2", out_data, v);
        wait_done();

        // beat-count error flag (stays 0 when checking is not built in)
        do_start(2'd0);
        send(1'b0);
        send(1'b0);
        send(1'b1);
        chk("bc_err_set", err, ERR_EXP);
        wait_done();
        chk("bc_err_sticky", err, ERR_EXP);
        tick();
        chk("bc_err_idle", err, ERR_EXP);
        do_start(2'd0);
        chk("bc_err_cleared", err, 0);
        send(1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
